// File: rtl/store_align_buf.sv
// rtl/store_align_buf.sv - two-entry aligning store buffer in front of data memory
//
// store_align_q: 2-deep in-order queue of {word addr, wdata, be} entries.
//   clk, reset_n            clock, synchronous active-low reset
//   push, push_data         enqueue one entry (caller guarantees count<2)
//   pop                     dequeue head (caller guarantees count>0)
//   head                    oldest entry
//   count                   number of held entries (0..2)
//   slot0, slot1            raw storage of each slot, for address matching
//   slot_valid              per-slot occupancy
//
// store_align_buf: accepts sw/sh/sb stores, lane-aligns them, rejects
// misaligned/reserved ones, and presents the oldest entry to memory.
//   clk, reset_n            clock, synchronous active-low reset
//   st_valid/st_ready       store request handshake
//   st_type, st_addr,       store type (0 sw, 1 sh, 2 sb, 3 reserved),
//   st_data                 byte address, register-aligned source data
//   mem_we, mem_ack         write request / head accepted by memory
//   mem_addr, mem_wdata,    head entry: word address, lane-aligned data,
//   mem_be                  byte enables (all zero when mem_we=0)
//   ld_addr, ld_hit         load address / buffered store to same word
//   st_err, err_addr        one-cycle reject pulse / address of last reject
//   drained                 buffer empty

module store_align_q #(
    parameter int W = 66
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic [W-1:0] slot0,
    output logic [W-1:0] slot1,
    output logic [1:0]   slot_valid
);

    logic [W-1:0] mem [0:1];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    // Guard against caller misuse so count can never wrap.
    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign slot0 = mem[1'b0];
    assign slot1 = mem[1'b1];

    // With one entry only the slot under rd_ptr is live; with two, both are.
    assign slot_valid[0] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'b0));
    assign slot_valid[1] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'b1));

endmodule

module store_align_buf (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        st_err,
    output logic [31:0] err_addr,
    output logic        drained
);

    localparam int EW = 30 + 32 + 4;

    localparam logic [1:0] T_SW = 2'd0;
    localparam logic [1:0] T_SH = 2'd1;
    localparam logic [1:0] T_SB = 2'd2;

    logic          accept;
    logic          bad;
    logic          push;
    logic          pop;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [EW-1:0] head;
    logic [EW-1:0] slot0;
    logic [EW-1:0] slot1;
    logic [1:0]    slot_valid;
    logic [1:0]    count;
    logic [29:0]   head_waddr;
    logic [31:0]   head_wdata;
    logic [3:0]    head_be;
    logic          ld_addr_unused;

    // Lane alignment and legality check of the incoming request.
    always_comb begin
        al_be    = 4'b0000;
        al_wdata = 32'h0;
        bad      = 1'b0;
        case (st_type)
            T_SW: begin
                bad      = (st_addr[1:0] != 2'b00);
                al_be    = 4'b1111;
                al_wdata = st_data;
            end
            T_SH: begin
                bad = st_addr[0];
                if (st_addr[1]) begin
                    al_be    = 4'b1100;
                    al_wdata = {st_data[15:0], 16'h0};
                end else begin
                    al_be    = 4'b0011;
                    al_wdata = {16'h0, st_data[15:0]};
                end
            end
            T_SB: begin
                al_be = 4'b0001 << st_addr[1:0];
                case (st_addr[1:0])
                    2'd0:    al_wdata = {24'h0, st_data[7:0]};
                    2'd1:    al_wdata = {16'h0, st_data[7:0], 8'h0};
                    2'd2:    al_wdata = {8'h0, st_data[7:0], 16'h0};
                    default: al_wdata = {st_data[7:0], 24'h0};
                endcase
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

    // st_ready is a function of occupancy only; a full buffer waits a cycle
    // after a pop before accepting again.
    assign st_ready = (count < 2'd2);
    assign accept   = st_valid && st_ready;
    assign push     = accept && !bad;
    assign pop      = mem_we && mem_ack;

    store_align_q #(.W(EW)) u_q (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  ({st_addr[31:2], al_wdata, al_be}),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .slot0      (slot0),
        .slot1      (slot1),
        .slot_valid (slot_valid)
    );

    assign head_waddr = head[EW-1:36];
    assign head_wdata = head[35:4];
    assign head_be    = head[3:0];

    assign mem_we    = (count != 2'd0);
    assign drained   = (count == 2'd0);
    assign mem_addr  = mem_we ? {head_waddr, 2'b00} : 32'h0;
    assign mem_wdata = mem_we ? head_wdata : 32'h0;
    assign mem_be    = mem_we ? head_be : 4'b0000;

    // Word-granular match; byte enables are deliberately not consulted.
    assign ld_hit = (slot_valid[0] && (slot0[EW-1:36] == ld_addr[31:2])) ||
                    (slot_valid[1] && (slot1[EW-1:36] == ld_addr[31:2]));
    assign ld_addr_unused = ^ld_addr[1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_err   <= 1'b0;
            err_addr <= 32'h0;
        end else begin
            st_err <= accept && bad;
            if (accept && bad) begin
                err_addr <= st_addr;
            end
        end
    end

endmodule

// File: tb/tb_store_align_buf.sv
// tb/tb_store_align_buf.sv - self-checking bench for store_align_buf

module tb_store_align_buf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_we;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        st_err;
    logic [31:0] err_addr;
    logic        drained;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    store_align_buf dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_type   (st_type),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .st_err    (st_err),
        .err_addr  (err_addr),
        .drained   (drained)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rn;
        logic        v;
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic        ack;
        logic [31:0] la;
        logic        we;
        logic [31:0] ma;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rdy;
        logic        err;
        logic [31:0] ea;
        logic        hit;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rn, input logic v, input logic [1:0] t, input logic [31:0] a,
        input logic [31:0] d, input logic ack, input logic [31:0] la,
        input logic we, input logic [31:0] ma, input logic [31:0] wd, input logic [3:0] be,
        input logic rdy, input logic err, input logic [31:0] ea, input logic hit);
        vec_t r;
        r.rn = rn; r.v = v; r.t = t; r.a = a; r.d = d; r.ack = ack; r.la = la;
        r.we = we; r.ma = ma; r.wd = wd; r.be = be; r.rdy = rdy; r.err = err;
        r.ea = ea; r.hit = hit;
        return r;
    endfunction

    // Reference model: list of pending stores in acceptance order.
    typedef struct {
        logic [29:0] wa;
        logic [31:0] wd;
        logic [3:0]  be;
    } ent_t;

    ent_t        mq[$];
    logic        m_err;
    logic [31:0] m_ea;

    function automatic void align(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                                  output bit bad, output logic [31:0] wd, output logic [3:0] be);
        int off;
        off = int'(a % 4);
        bad = 0; wd = 0; be = 0;
        case (t)
            2'd0: begin bad = (off != 0); be = 4'hF; wd = d; end
            2'd1: begin bad = (off % 2 != 0); be = 4'(3 << off); wd = (d & 32'hFFFF) << (8 * off); end
            2'd2: begin be = 4'(1 << off); wd = (d & 32'hFF) << (8 * off); end
            default: bad = 1;
        endcase
    endfunction

    task automatic model_step();
        bit          bad;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          acc;
        ent_t        e;
        if (!reset_n) begin
            mq.delete();
            m_err = 0;
            m_ea  = 0;
        end else begin
            acc = st_valid && (mq.size() < 2);
            align(st_type, st_addr, st_data, bad, wd, be);
            if (mq.size() > 0 && mem_ack) void'(mq.pop_front());
            m_err = acc && bad;
            if (acc && bad) m_ea = st_addr;
            if (acc && !bad) begin
                e.wa = st_addr[31:2]; e.wd = wd; e.be = be;
                mq.push_back(e);
            end
        end
    endtask

    task automatic model_check();
        bit hit;
        hit = 0;
        foreach (mq[i]) if (mq[i].wa == ld_addr[31:2]) hit = 1;
        chk("rnd_we", 32'(mem_we), 32'(mq.size() > 0));
        chk("rnd_ready", 32'(st_ready), 32'(mq.size() < 2));
        chk("rnd_drained", 32'(drained), 32'(mq.size() == 0));
        chk("rnd_addr", mem_addr, (mq.size() > 0) ? {mq[0].wa, 2'b00} : 32'h0);
        chk("rnd_wdata", mem_wdata, (mq.size() > 0) ? mq[0].wd : 32'h0);
        chk("rnd_be", 32'(mem_be), (mq.size() > 0) ? 32'(mq[0].be) : 32'h0);
        chk("rnd_err", 32'(st_err), 32'(m_err));
        chk("rnd_err_addr", err_addr, m_ea);
        chk("rnd_hit", 32'(ld_hit), 32'(hit));
    endtask

    initial begin
        reset_n = 1'b0; st_valid = 1'b0; st_type = 2'd0; st_addr = 32'h0;
        st_data = 32'h0; mem_ack = 1'b0; ld_addr = 32'h0;

        //            rn v  t  addr          data          ack la            we ma            wd            be     rdy err ea            hit
        tbl.push_back(mk(0, 1, 0, 32'h0000_5000, 32'hFFFF_FFFF, 1, 32'h0,         0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 1, 2, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0,         1, 32'h0000_1000, 32'hA500_0000, 4'h8, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 1, 1, 32'h0000_2002, 32'h1234_BEEF, 0, 32'h0,         1, 32'h0000_2000, 32'hBEEF_0000, 4'hC, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 1, 0, 32'h0000_2004, 32'h1234_BEEF, 1, 32'h0,         1, 32'h0000_2004, 32'h1234_BEEF, 4'hF, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 1, 0, 32'h0000_0100, 32'h1111_1111, 0, 32'h0,         1, 32'h0000_0100, 32'h1111_1111, 4'hF, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 1, 0, 32'h0000_0104, 32'h2222_2222, 0, 32'h0,         1, 32'h0000_0100, 32'h1111_1111, 4'hF, 0, 0, 32'h0,         0));
        tbl.push_back(mk(1, 1, 0, 32'h0000_0108, 32'h3333_3333, 0, 32'h0,         1, 32'h0000_0100, 32'h1111_1111, 4'hF, 0, 0, 32'h0,         0));
        tbl.push_back(mk(1, 1, 0, 32'h0000_0108, 32'h3333_3333, 1, 32'h0,         1, 32'h0000_0104, 32'h2222_2222, 4'hF, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 1, 0, 32'h0000_0108, 32'h3333_3333, 0, 32'h0,         1, 32'h0000_0104, 32'h2222_2222, 4'hF, 0, 0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0,         1, 32'h0,         1, 32'h0000_0108, 32'h3333_3333, 4'hF, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 1, 0, 32'h0000_3002, 32'hDEAD_BEEF, 0, 32'h0,         0, 32'h0,         32'h0,         4'h0, 1, 1, 32'h0000_3002, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h0000_3002, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0000_4008, 32'hCAFE_F00D, 0, 32'h0000_400B, 1, 32'h0000_4008, 32'hCAFE_F00D, 4'hF, 1, 0, 32'h0000_3002, 1));
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0,         0, 32'h0000_400C, 1, 32'h0000_4008, 32'hCAFE_F00D, 4'hF, 1, 0, 32'h0000_3002, 0));
        tbl.push_back(mk(1, 1, 3, 32'h0000_4000, 32'h0,         0, 32'h0000_4008, 1, 32'h0000_4008, 32'hCAFE_F00D, 4'hF, 1, 1, 32'h0000_4000, 1));
        tbl.push_back(mk(1, 1, 1, 32'h0000_4001, 32'h0,         0, 32'h0,         1, 32'h0000_4008, 32'hCAFE_F00D, 4'hF, 1, 1, 32'h0000_4001, 0));
        tbl.push_back(mk(1, 1, 2, 32'h0000_5001, 32'h0000_0077, 0, 32'h0000_5003, 1, 32'h0000_4008, 32'hCAFE_F00D, 4'hF, 0, 0, 32'h0000_4001, 1));
        tbl.push_back(mk(0, 1, 0, 32'h0000_7000, 32'h0,         1, 32'h0000_5000, 0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0,         1, 32'h0000_4008, 0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 1, 2, 32'h0000_6001, 32'h1234_5677, 0, 32'h0,         1, 32'h0000_6000, 32'h0000_7700, 4'h2, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 1, 1, 32'h0000_6000, 32'hAAAA_5555, 1, 32'h0,         1, 32'h0000_6000, 32'h0000_5555, 4'h3, 1, 0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h0,         0));

        foreach (tbl[i]) begin
            reset_n = tbl[i].rn; st_valid = tbl[i].v; st_type = tbl[i].t;
            st_addr = tbl[i].a; st_data = tbl[i].d; mem_ack = tbl[i].ack;
            ld_addr = tbl[i].la;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
            chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].ma);
            chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].wd);
            chk($sformatf("v%0d_be", i), 32'(mem_be), 32'(tbl[i].be));
            chk($sformatf("v%0d_ready", i), 32'(st_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_drained", i), 32'(drained), 32'(!tbl[i].we));
            chk($sformatf("v%0d_err", i), 32'(st_err), 32'(tbl[i].err));
            chk($sformatf("v%0d_err_addr", i), err_addr, tbl[i].ea);
            chk($sformatf("v%0d_hit", i), 32'(ld_hit), 32'(tbl[i].hit));
        end

        // Randomized traffic over a small address window so loads hit often.
        for (int c = 0; c < 3000; c++) begin
            reset_n  = (c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            st_valid = $urandom_range(0, 2) != 0;
            st_type  = 2'($urandom_range(0, 3));
            st_addr  = 32'h0000_8000 + 32'($urandom_range(0, 31));
            st_data  = $urandom;
            mem_ack  = $urandom_range(0, 2) == 0;
            ld_addr  = 32'h0000_8000 + 32'($urandom_range(0, 31));
            model_step();
            @(posedge clk);
            #1;
            model_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
